// File: rtl/mc_pkg.sv
// Shared types and encodings for the multi-cycle RV32I control sequencer.
// Holds the FSM state enum, opcode constants, ALU op codes and mux encodings.
// Optional feature macro used by the block: MC_INSTRET_EN (retire counter).
package mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10,
    S_TRAP     = 4'd11
  } mc_state_e;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic       ADR_PC     = 1'b0;
  localparam logic       ADR_ALUOUT = 1'b1;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RD1   = 2'b10;

  localparam logic [1:0] SRCB_RD2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  // DECODE successor for a given opcode; anything unsupported traps.
  function automatic mc_state_e decode_next(input logic [6:0] op);
    case (op)
      OP_LOAD, OP_STORE: decode_next = S_MEMADR;
      OP_RTYPE:          decode_next = S_EXECR;
      OP_ITYPE:          decode_next = S_EXECI;
      OP_BRANCH:         decode_next = S_BEQ;
      OP_JAL:            decode_next = S_JAL;
      default:           decode_next = S_TRAP;
    endcase
  endfunction

endpackage

// File: rtl/mc_instret_counter.sv
// 32-bit retired-instruction counter, wraps 0xFFFFFFFF -> 0.
// Ports: clk, rst (sync active-high clear), inc (count one retirement), count.
// Built only when MC_INSTRET_EN is defined at the top level.
module mc_instret_counter (
  input  logic        clk,
  input  logic        rst,
  input  logic        inc,
  output logic [31:0] count
);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (inc) begin
      count <= count + 32'd1;
    end
  end

endmodule

// File: rtl/mc_control_fsm.sv
// Multi-cycle control sequencer: steps one RV32I instruction through
// fetch/decode/execute/memory/writeback sharing one ALU and one memory port.
// Ports: clk, rst (sync active-high), opcode, zero, mem_ready in; mux selects,
// write enables, alu_op, sticky illegal and instret out.
// Macro MC_INSTRET_EN: builds the retire counter; otherwise instret is 0.
module mc_control_fsm
  import mc_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  opcode,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        pc_write,
  output logic        adr_src,
  output logic        mem_write,
  output logic        ir_write,
  output logic [1:0]  result_src,
  output logic [1:0]  alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [1:0]  alu_op,
  output logic        reg_write,
  output logic        illegal,
  output logic [31:0] instret
);

  mc_state_e state;

  // State register and sticky illegal flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_FETCH;
      illegal <= 1'b0;
    end else begin
      case (state)
        S_FETCH:    if (mem_ready) state <= S_DECODE;
        S_DECODE: begin
          state <= decode_next(opcode);
          if (decode_next(opcode) == S_TRAP) illegal <= 1'b1;
        end
        // IR still holds the opcode, so it tells load from store here.
        S_MEMADR:   state <= (opcode == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
        S_MEMREAD:  if (mem_ready) state <= S_MEMWB;
        S_MEMWB:    state <= S_FETCH;
        S_MEMWRITE: if (mem_ready) state <= S_FETCH;
        S_EXECR:    state <= S_ALUWB;
        S_EXECI:    state <= S_ALUWB;
        S_ALUWB:    state <= S_FETCH;
        S_BEQ:      state <= S_FETCH;
        S_JAL:      state <= S_ALUWB;
        S_TRAP:     state <= S_TRAP;
        default:    state <= S_FETCH;
      endcase
    end
  end

  // Output decode from state. Only FETCH (mem_ready) and BEQ (zero) look at
  // inputs, and only to gate their enables; reset masks every enable and
  // presents the FETCH mux selects.
  always_comb begin
    pc_write   = 1'b0;
    adr_src    = ADR_PC;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    result_src = RES_ALUOUT;
    alu_src_a  = SRCA_PC;
    alu_src_b  = SRCB_RD2;
    alu_op     = ALU_ADD;
    reg_write  = 1'b0;
    if (rst) begin
      result_src = RES_ALURESULT;
      alu_src_b  = SRCB_FOUR;
    end else begin
      case (state)
        S_FETCH: begin
          result_src = RES_ALURESULT;
          alu_src_b  = SRCB_FOUR;
          ir_write   = mem_ready;
          pc_write   = mem_ready;
        end
        S_DECODE: begin
          alu_src_a = SRCA_OLDPC;
          alu_src_b = SRCB_IMM;
        end
        S_MEMADR: begin
          alu_src_a = SRCA_RD1;
          alu_src_b = SRCB_IMM;
        end
        S_MEMREAD: begin
          adr_src = ADR_ALUOUT;
        end
        S_MEMWB: begin
          result_src = RES_DATA;
          reg_write  = 1'b1;
        end
        S_MEMWRITE: begin
          adr_src   = ADR_ALUOUT;
          mem_write = 1'b1;
        end
        S_EXECR: begin
          alu_src_a = SRCA_RD1;
          alu_op    = ALU_FUNCT;
        end
        S_EXECI: begin
          alu_src_a = SRCA_RD1;
          alu_src_b = SRCB_IMM;
          alu_op    = ALU_FUNCT;
        end
        S_ALUWB: begin
          reg_write = 1'b1;
        end
        S_BEQ: begin
          alu_src_a = SRCA_RD1;
          alu_op    = ALU_SUB;
          pc_write  = zero;
        end
        S_JAL: begin
          alu_src_a = SRCA_OLDPC;
          alu_src_b = SRCB_FOUR;
          pc_write  = 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

`ifdef MC_INSTRET_EN
  logic retire;

  // Retire on the edge leaving a final state; a store only when it completes.
  assign retire = (state == S_MEMWB) || (state == S_ALUWB) || (state == S_BEQ) ||
                  ((state == S_MEMWRITE) && mem_ready);

  mc_instret_counter u_instret (
    .clk   (clk),
    .rst   (rst),
    .inc   (retire),
    .count (instret)
  );
`else
  assign instret = '0;
`endif

endmodule

// File: tb/tb_mc_control_fsm.sv
// Directed bench for mc_control_fsm: per-cycle output vectors vs hand-built tables.
// Outputs are packed as {pc_write, adr_src, mem_write, ir_write, result_src,
// alu_src_a, alu_src_b, alu_op, reg_write, illegal}.
module tb_mc_control_fsm;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [6:0]  opcode = 7'b0110011;
  logic        zero = 1'b0;
  logic        mem_ready = 1'b0;
  logic        pc_write, adr_src, mem_write, ir_write, reg_write, illegal;
  logic [1:0]  result_src, alu_src_a, alu_src_b, alu_op;
  logic [31:0] instret;
  logic [13:0] outs;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mc_control_fsm dut (
    .clk        (clk),
    .rst        (rst),
    .opcode     (opcode),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .pc_write   (pc_write),
    .adr_src    (adr_src),
    .mem_write  (mem_write),
    .ir_write   (ir_write),
    .result_src (result_src),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .alu_op     (alu_op),
    .reg_write  (reg_write),
    .illegal    (illegal),
    .instret    (instret)
  );

  assign outs = {pc_write, adr_src, mem_write, ir_write, result_src,
                 alu_src_a, alu_src_b, alu_op, reg_write, illegal};

  localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011;
  localparam logic [6:0] IT = 7'b0010011, BR = 7'b1100011, JL = 7'b1101111;

  //                              pc a mw ir  rs   a    b    op  rw il
  localparam logic [13:0] V_FR   = 14'b1_0_0_1_10_00_10_00_0_0;
  localparam logic [13:0] V_FW   = 14'b0_0_0_0_10_00_10_00_0_0;
  localparam logic [13:0] V_RST  = 14'b0_0_0_0_10_00_10_00_0_0;
  localparam logic [13:0] V_RSTI = 14'b0_0_0_0_10_00_10_00_0_1;
  localparam logic [13:0] V_DEC  = 14'b0_0_0_0_00_01_01_00_0_0;
  localparam logic [13:0] V_MADR = 14'b0_0_0_0_00_10_01_00_0_0;
  localparam logic [13:0] V_MRD  = 14'b0_1_0_0_00_00_00_00_0_0;
  localparam logic [13:0] V_MWB  = 14'b0_0_0_0_01_00_00_00_1_0;
  localparam logic [13:0] V_MWR  = 14'b0_1_1_0_00_00_00_00_0_0;
  localparam logic [13:0] V_EXR  = 14'b0_0_0_0_00_10_00_10_0_0;
  localparam logic [13:0] V_EXI  = 14'b0_0_0_0_00_10_01_10_0_0;
  localparam logic [13:0] V_AWB  = 14'b0_0_0_0_00_00_00_00_1_0;
  localparam logic [13:0] V_BEQT = 14'b1_0_0_0_00_10_00_01_0_0;
  localparam logic [13:0] V_BEQN = 14'b0_0_0_0_00_10_00_01_0_0;
  localparam logic [13:0] V_JAL  = 14'b1_0_0_0_00_01_10_00_0_0;
  localparam logic [13:0] V_TRAP = 14'b0_0_0_0_00_00_00_00_0_1;

  // Every task starts 1 time unit after a rising edge with the DUT in FETCH.
  task automatic test_reset();
    rst = 1'b1; mem_ready = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 2; i++) begin
      mem_ready = 1'(i);
      #1;
      n_cmp++;
      if (outs !== V_RST) begin
        n_fail++;
        $display("FAIL reset_outs cyc%0d: got %b want %b", i, outs, V_RST);
      end
      n_cmp++;
      if (instret !== 32'd0) begin
        n_fail++;
        $display("FAIL reset_instret: got %0d want 0", instret);
      end
      @(posedge clk); #1;
    end
    rst = 1'b0; mem_ready = 1'b0;
    #1;
    n_cmp++;
    if (outs !== V_FW) begin
      n_fail++;
      $display("FAIL reset_fetch_wait: got %b want %b", outs, V_FW);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_alu();
    logic [6:0]  op [9] = '{RT, RT, RT, RT, IT, IT, IT, IT, IT};
    bit          mr [9] = '{1, 1, 1, 1, 1, 0, 0, 1, 0};
    logic [13:0] ex [9] = '{V_FR, V_DEC, V_EXR, V_AWB, V_FR, V_DEC, V_EXI, V_AWB, V_FW};
    for (int i = 0; i < 9; i++) begin
      opcode = op[i]; mem_ready = mr[i]; zero = 1'b0;
      #1;
      n_cmp++;
      if (outs !== ex[i]) begin
        n_fail++;
        $display("FAIL alu cyc%0d: got %b want %b", i, outs, ex[i]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_lw_wait();
    bit          mr [8] = '{1, 1, 1, 0, 0, 1, 1, 0};
    logic [13:0] ex [8] = '{V_FR, V_DEC, V_MADR, V_MRD, V_MRD, V_MRD, V_MWB, V_FW};
    opcode = LW;
    for (int i = 0; i < 8; i++) begin
      mem_ready = mr[i];
      #1;
      n_cmp++;
      if (outs !== ex[i]) begin
        n_fail++;
        $display("FAIL lw_wait cyc%0d: got %b want %b", i, outs, ex[i]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_beq();
    bit          zr [7] = '{0, 0, 1, 1, 1, 0, 0};
    bit          mr [7] = '{1, 0, 0, 1, 0, 1, 0};
    logic [13:0] ex [7] = '{V_FR, V_DEC, V_BEQT, V_FR, V_DEC, V_BEQN, V_FW};
    opcode = BR;
    for (int i = 0; i < 7; i++) begin
      zero = zr[i]; mem_ready = mr[i];
      #1;
      n_cmp++;
      if (outs !== ex[i]) begin
        n_fail++;
        $display("FAIL beq cyc%0d: got %b want %b", i, outs, ex[i]);
      end
      @(posedge clk); #1;
    end
    zero = 1'b0;
  endtask

  task automatic test_sw_abort();
    bit          mr [12] = '{1, 1, 1, 0, 1, 1, 1, 1, 0, 0, 0, 0};
    bit          rs [12] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0};
    logic [13:0] ex [12] = '{V_FR, V_DEC, V_MADR, V_MWR, V_MWR,
                             V_FR, V_DEC, V_MADR, V_MWR, V_MWR, V_RST, V_FW};
    opcode = SW;
    for (int i = 0; i < 12; i++) begin
      mem_ready = mr[i]; rst = rs[i];
      #1;
      n_cmp++;
      if (outs !== ex[i]) begin
        n_fail++;
        $display("FAIL sw_abort cyc%0d: got %b want %b", i, outs, ex[i]);
      end
      @(posedge clk); #1;
    end
    n_cmp++;
    if (instret !== 32'd0) begin
      n_fail++;
      $display("FAIL sw_abort_instret: got %0d want 0", instret);
    end
  endtask

  task automatic test_trap();
    bit          rs [14];
    logic [13:0] ex [14];
    opcode = 7'h7F;
    for (int i = 0; i < 14; i++) begin
      rs[i] = (i == 12);
      ex[i] = (i == 0) ? V_FR : (i == 1) ? V_DEC : (i < 12) ? V_TRAP :
              (i == 12) ? V_RSTI : V_FW;
    end
    for (int i = 0; i < 14; i++) begin
      mem_ready = (i != 13); zero = 1'(i); rst = rs[i];
      #1;
      n_cmp++;
      if (outs !== ex[i]) begin
        n_fail++;
        $display("FAIL trap cyc%0d: got %b want %b", i, outs, ex[i]);
      end
      @(posedge clk); #1;
    end
    zero = 1'b0;
  endtask

  task automatic test_instret();
    logic [6:0]  op [13] = '{RT, RT, RT, RT, SW, SW, SW, SW, JL, JL, JL, JL, JL};
    bit          mr [13] = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 0};
    logic [13:0] ex [13] = '{V_FR, V_DEC, V_EXR, V_AWB, V_FR, V_DEC, V_MADR, V_MWR,
                             V_FR, V_DEC, V_JAL, V_AWB, V_FW};
    logic [31:0] want;
    for (int i = 0; i < 13; i++) begin
      opcode = op[i]; mem_ready = mr[i];
      #1;
      n_cmp++;
      if (outs !== ex[i]) begin
        n_fail++;
        $display("FAIL instret_seq cyc%0d: got %b want %b", i, outs, ex[i]);
      end
      @(posedge clk); #1;
    end
`ifdef MC_INSTRET_EN
    want = 32'd3;
`else
    want = 32'd0;
`endif
    n_cmp++;
    if (instret !== want) begin
      n_fail++;
      $display("FAIL instret_count: got %0d want %0d", instret, want);
    end
`ifdef MC_INSTRET_EN
    dut.u_instret.count = 32'hFFFF_FFFF;
    opcode = BR; zero = 1'b0;
    for (int i = 0; i < 4; i++) begin
      mem_ready = (i == 0);
      @(posedge clk); #1;
    end
    n_cmp++;
    if (instret !== 32'd0) begin
      n_fail++;
      $display("FAIL instret_wrap: got %h want 00000000", instret);
    end
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_alu();
    test_lw_wait();
    test_beq();
    test_sw_abort();
    test_trap();
    test_instret();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
